// File: rtl/comm_pkg.sv
// -----------------------------------------------------------------------------
// comm_pkg
// Types and constants shared by the per-channel UART transmit stage that sits
// after the read-address / RD-strobe generator.
//
// Contents:
//   WORDS_PER_PKT  bytes per packet (buffer RAM address range 0..17)
//   RD_SLOT_CLKS   clk cycles between consecutive RD strobes
//   tx_state_t     serializer FSM states
//   even_parity()  XOR reduction of a data byte
//
// Build option: RD_UART_PARITY_EN adds a PARITY state to tx_state_t.
// -----------------------------------------------------------------------------
package comm_pkg;

    localparam int WORDS_PER_PKT = 18;
    localparam int RD_SLOT_CLKS  = 65;

`ifdef RD_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small circular byte FIFO. A push that finds the FIFO full with no pop in
// the same cycle is dropped and sets the sticky ovf flag. A push and a pop in
// the same cycle on a full FIFO both take effect.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push, din  write request and data
//   pop        read request (ignored when empty)
//   dout       head of the FIFO, valid whenever empty = 0
//   full       count == DEPTH
//   empty      count == 0
//   count      current occupancy
//   ovf        sticky: at least one byte was dropped since reset
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    logic do_pop;
    logic do_push;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push & ~do_push) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // The serializer loads the head on the same edge it pops, so the head is
    // read asynchronously (small distributed memory).
    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/rd_uart_tx.sv
// -----------------------------------------------------------------------------
// rd_uart_tx
// One UART channel downstream of the RD-strobe generator. Each rising edge of
// RD captures rd_data into a byte FIFO; queued bytes are sent LSB first as
// 8N1 frames on tx. pkt_done pulses during the last stop-bit cycle of every
// WORDS-th transmitted byte.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   RD        read strobe (multi-cycle, rising edge captures)
//   rd_data   buffer RAM data, stable while RD is high
//   tx        serial line, idle high, registered
//   busy      frame in progress or FIFO non-empty
//   pkt_done  one-cycle pulse at the end of the packet's final stop bit
//   ovf       sticky FIFO overflow
//   fifo_cnt  FIFO occupancy
//
// Build option: RD_UART_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit (11-bit frame).
// -----------------------------------------------------------------------------
module rd_uart_tx
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int WORDS        = WORDS_PER_PKT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RD,
    input  logic [7:0]                    rd_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

    // RD edge detect
    logic rd_q_reg;
    logic push;

    // FIFO interface
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Serializer state
    tx_state_t         state_reg,    state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_idx_reg,  bit_idx_next;
    logic [7:0]        shreg_reg,    shreg_next;
    logic [WORD_W-1:0] word_cnt_reg, word_cnt_next;
    logic              tx_reg,       tx_next;
    logic              pkt_done_reg, pkt_done_next;
    logic              baud_last;

    assign push = RD & ~rd_q_reg;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rd_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .ovf   (ovf)
    );

    assign baud_last = (baud_cnt_reg == BAUD_LAST);

    // State register. tx and pkt_done are registered from the current state,
    // so the line lags the FSM by one clk and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shreg_reg    <= '0;
            word_cnt_reg <= '0;
            rd_q_reg     <= 1'b0;
            tx_reg       <= 1'b1;
            pkt_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shreg_reg    <= shreg_next;
            word_cnt_reg <= word_cnt_next;
            rd_q_reg     <= RD;
            tx_reg       <= tx_next;
            pkt_done_reg <= pkt_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shreg_next    = shreg_reg;
        word_cnt_next = word_cnt_reg;
        fifo_pop      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shreg_next    = fifo_dout;
                    baud_cnt_next = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
`ifdef RD_UART_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
`ifdef RD_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = ST_STOP;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    word_cnt_next = (word_cnt_reg == WORD_LAST) ? '0
                                  : word_cnt_reg + WORD_W'(1);
                    state_next    = ST_IDLE;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode (registered in the state process)
    always_comb begin
        tx_next       = 1'b1;
        pkt_done_next = 1'b0;
        unique case (state_reg)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shreg_reg[bit_idx_reg];
`ifdef RD_UART_PARITY_EN
            ST_PARITY: tx_next = even_parity(shreg_reg);
`endif
            ST_STOP:  pkt_done_next = baud_last & (word_cnt_reg == WORD_LAST);
            default:  tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_reg;
    assign pkt_done = pkt_done_reg;
    assign fifo_cnt = fifo_count;
    assign busy     = (state_reg != ST_IDLE) | (fifo_count != '0);

    // The FIFO's full flag must agree with its occupancy count.
    a_full_consistent: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_rd_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_rd_uart_tx
// Self-checking bench for rd_uart_tx. A frame-schedule reference model
// predicts tx/busy/pkt_done/ovf/fifo_cnt after every clk edge; a line
// decoder recovers transmitted frames for the directed and table-driven
// checks. With RD_UART_PARITY_EN defined the bench runs 5 clks per bit and
// expects 11-bit frames.
// -----------------------------------------------------------------------------
module tb_rd_uart_tx;

`ifdef RD_UART_PARITY_EN
    localparam int CPB   = 5;
    localparam int NBITS = 11;
`else
    localparam int CPB   = 6;
    localparam int NBITS = 10;
`endif
    localparam int DEPTH = 4;
    localparam int WORDS = 18;
    localparam int SLOT  = 65;
    localparam int L     = CPB * NBITS;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          RD      = 1'b0;
    logic [7:0]    rd_data = 8'h00;
    logic          tx;
    logic          busy;
    logic          pkt_done;
    logic          ovf;
    logic [CW-1:0] fifo_cnt;

    rd_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .WORDS        (WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RD       (RD),
        .rd_data  (rd_data),
        .tx       (tx),
        .busy     (busy),
        .pkt_done (pkt_done),
        .ovf      (ovf),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes wait in mq; a frame popped at edge E drives the line low from
    // edge E+1 for L clks; the next pop may happen at E+L+1.
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] m_byte;
    int  m_start, next_free, m_word, m_k, m_sz;
    bit  m_act, m_ovf, m_rdq, m_valid, m_pop, m_push;
    bit  e_tx, e_busy, e_pkt;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_act = 0; next_free = 0; m_word = 0; m_ovf = 0; m_rdq = 0; m_valid = 1;
        end else begin
            m_sz   = mq.size();
            m_pop  = (m_sz > 0) && (cyc >= next_free);
            m_push = RD && !m_rdq;
            m_rdq  = RD;
            if (m_pop) begin
                m_byte = mq.pop_front();
                m_start = cyc; m_act = 1; next_free = cyc + L + 1;
            end
            if (m_push) begin
                if (m_sz == DEPTH && !m_pop) m_ovf = 1;
                else mq.push_back(rd_data);
            end
        end
        e_tx = 1; e_pkt = 0; e_busy = 0;
        if (m_act) begin
            if (cyc >= m_start + 1 && cyc <= m_start + L) begin
                m_k = (cyc - 1 - m_start) / CPB;
                if (m_k == 0)      e_tx = 0;
                else if (m_k <= 8) e_tx = m_byte[m_k-1];
                else if (m_k == 9 && NBITS == 11) e_tx = ^m_byte;
                else               e_tx = 1;
            end
            e_busy = (cyc >= m_start) && (cyc <= m_start + L - 1);
            if (cyc == m_start + L) begin
                sent_q.push_back(m_byte);
                m_word++;
                if (m_word == WORDS) begin e_pkt = 1; m_word = 0; end
                m_act = 0;
            end
        end
        if (mq.size() > 0) e_busy = 1;
    end

    always @(negedge clk) begin
        if (m_valid && errors < 50) begin
            check("tx", tx, e_tx);
            check("busy", busy, e_busy);
            check("pkt_done", pkt_done, e_pkt);
            check("ovf", ovf, m_ovf);
            check("fifo_cnt", fifo_cnt, mq.size());
        end
    end

    // ---------------- line decoder and monitors ----------------
    bit         rx_act = 0;
    int         rx_start;
    logic [10:0] rx_bits;
    logic [10:0] rx_frame_q[$];
    int         rx_start_q[$];
    int         pkt_seen = 0;
    int         max_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 0;
        end else begin
            if (!rx_act && tx == 1'b0) begin
                rx_act = 1; rx_start = cyc; rx_bits = '0;
            end
            if (rx_act) begin
                for (int k = 0; k < NBITS; k++)
                    if (cyc == rx_start + k * CPB + CPB / 2) rx_bits[k] = tx;
                if (cyc == rx_start + (NBITS - 1) * CPB + CPB / 2) begin
                    rx_act = 0;
                    rx_frame_q.push_back(rx_bits);
                    rx_start_q.push_back(rx_start);
                    $display("frame cycle=%0d data=%02h line=%03h", rx_start, rx_bits[8:1], rx_bits);
                end
            end
            if (pkt_done === 1'b1) pkt_seen++;
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1; RD = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic pulse(input logic [7:0] d, input int hold, input int low, output int edge_n);
        rd_data = d; RD = 1;
        edge_n = cyc + 1;
        $display("rd edge=%0d data=%02h hold=%0d", edge_n, d, hold);
        tick(hold);
        RD = 0;
        tick(low);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy !== 1'b0 || rx_act || tx !== 1'b1) && n < maxc) begin
            tick(1); n++;
        end
        tick(2);
        check("idle_timeout", (n < maxc), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic [9:0] exp_line;   // {stop, data[7:0], start}, first bit in [0]
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int pe, n0, p0, s0, hold, gap;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 4, 10'h34A, 1'b0};
        vecs[1] = '{8'h00, 1, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 2, 10'h3FE, 1'b0};
        vecs[3] = '{8'h07, 3, 10'h20E, 1'b1};
        vecs[4] = '{8'h03, 5, 10'h206, 1'b0};
        vecs[5] = '{8'h80, 7, 10'h300, 1'b1};

        // Reset state
        tick(2);
        rst = 0;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_pkt_done", pkt_done, 0);
        check("reset_ovf", ovf, 0);
        check("reset_fifo_cnt", fifo_cnt, 0);

        // Table: single bytes, various RD widths
        for (int i = 0; i < 6; i++) begin
            n0 = rx_frame_q.size();
            pulse(vecs[i].data, vecs[i].hold, 1, pe);
            wait_idle(400);
            check("tbl_frames", rx_frame_q.size() - n0, 1);
            if (rx_frame_q.size() > n0) begin
                check("tbl_start", rx_frame_q[n0][0], vecs[i].exp_line[0]);
                check("tbl_data", rx_frame_q[n0][8:1], vecs[i].exp_line[8:1]);
                check("tbl_stop", rx_frame_q[n0][NBITS-1], vecs[i].exp_line[9]);
                check("tbl_latency", rx_start_q[n0], pe + 2);
`ifdef RD_UART_PARITY_EN
                check("tbl_parity", rx_frame_q[n0][9], vecs[i].exp_par);
`endif
            end
            check("tbl_busy_end", busy, 0);
            check("tbl_cnt_end", fifo_cnt, 0);
        end

        // Full packet at the RD slot cadence
        do_reset();
        n0 = rx_frame_q.size(); p0 = pkt_seen; max_cnt = 0;
        for (int i = 0; i < WORDS; i++) pulse(8'(i), 4, SLOT - 4, pe);
        wait_idle(400);
        check("pkt_frames", rx_frame_q.size() - n0, WORDS);
        for (int i = 0; i < WORDS && n0 + i < rx_frame_q.size(); i++)
            check("pkt_data", rx_frame_q[n0+i][8:1], i);
        check("pkt_done_count", pkt_seen - p0, 1);
        check("pkt_ovf", ovf, 0);
        check("pkt_max_cnt", max_cnt, 1);

        // Overflow: six strobes two clks apart
        do_reset();
        n0 = rx_frame_q.size(); p0 = pkt_seen;
        for (int i = 1; i <= 6; i++) pulse(8'(i), 1, 1, pe);
        check("ovf_set", ovf, 1);
        wait_idle(1000);
        check("ovf_frames", rx_frame_q.size() - n0, 5);
        for (int i = 0; i < 5 && n0 + i < rx_frame_q.size(); i++)
            check("ovf_data", rx_frame_q[n0+i][8:1], i + 1);
        // five counted, so thirteen more complete the packet
        for (int i = 0; i < WORDS - 6; i++) pulse(8'(8'h40 + i), 2, SLOT - 2, pe);
        wait_idle(400);
        check("ovf_pkt_early", pkt_seen - p0, 0);
        pulse(8'h4D, 2, SLOT - 2, pe);
        wait_idle(400);
        check("ovf_pkt_done", pkt_seen - p0, 1);
        check("ovf_sticky", ovf, 1);

        // Long RD: one byte only
        n0 = rx_frame_q.size();
        pulse(8'h5A, 40, 2, pe);
        wait_idle(400);
        check("long_frames", rx_frame_q.size() - n0, 1);
        if (rx_frame_q.size() > n0) check("long_data", rx_frame_q[n0][8:1], 8'h5A);

        // Reset during data bit 3
        do_reset();
        for (int i = 0; i < 7; i++) pulse(8'(8'h70 + i), 4, SLOT - 4, pe);
        wait_idle(400);
        n0 = rx_frame_q.size();
        pulse(8'hC3, 1, 0, pe);
        tick(4 * CPB + 2);
        rst = 1;
        tick(1);
        rst = 0;
        check("mr_tx", tx, 1);
        check("mr_busy", busy, 0);
        check("mr_fifo_cnt", fifo_cnt, 0);
        check("mr_ovf", ovf, 0);
        tick(3 * L);
        check("mr_aborted", rx_frame_q.size() - n0, 0);
        p0 = pkt_seen; s0 = sent_q.size();
        for (int i = 0; i < WORDS; i++) begin
            d = 8'($urandom);
            hold = $urandom_range(1, 6);
            gap = $urandom_range(L + 2, L + 20);
            pulse(d, hold, gap - hold, pe);
            if (i == WORDS - 2) begin
                wait_idle(400);
                check("mr_pkt_early", pkt_seen - p0, 0);
            end
        end
        wait_idle(400);
        check("mr_pkt_done", pkt_seen - p0, 1);
        check("mr_sent", sent_q.size() - s0, WORDS);

        // Random bursts, overflow allowed
        do_reset();
        n0 = rx_frame_q.size(); s0 = sent_q.size();
        for (int i = 0; i < 60; i++) begin
            hold = $urandom_range(1, 5);
            pulse(8'($urandom), hold, $urandom_range(1, 40), pe);
        end
        wait_idle(2000);
        check("rnd_frames", rx_frame_q.size() - n0, sent_q.size() - s0);
        for (int i = 0; n0 + i < rx_frame_q.size() && s0 + i < sent_q.size(); i++)
            check("rnd_data", rx_frame_q[n0+i][8:1], sent_q[s0+i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
